// File: rtl/gpr_mp.sv
// gpr_mp: multi-port general-purpose register file for the MIPS core.
// NR combinational read ports, NW synchronous write ports, register 0 reads
// as zero, and a sequential clear engine that sweeps the file to zero after
// reset or on clr_req. While the sweep runs, writes are dropped and reads
// return zero.
//
// Optional feature: define GPR_MP_BYPASS_EN to forward same-cycle write data
// to matching read ports. Without it, reads show the stored contents only.
module gpr_mp #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int NR   = 2,
  parameter int NW   = 1,
  parameter int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR*DW-1:0] rd_data,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NW*DW-1:0] wr_data,
  input  logic             clr_req,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam logic [AW-1:0] LastReg = AW'(NREG - 1);
  localparam logic [AW-1:0] ZeroAddr = '0;

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic          busy_q;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  logic [NR*DW-1:0] rdData_d;

  // Clear-engine FSM: reset or an idle clr_req starts a full sweep from
  // register 0; busy is registered alongside the state so that it has no
  // combinational dependence on clr_req.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          ptr_q <= ptr_q + AW'(1);
          if (ptr_q == LastReg) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Next contents of the file: the sweep owns the file while clearing;
  // otherwise the write ports apply in ascending order so the highest-index
  // port wins a collision, and address 0 is never written by a port.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
    end
    if (rst) begin
      if (state_q == CLEAR) begin
        regs_d[ptr_q] = '0;
      end else begin
        for (int j = 0; j < NW; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] != ZeroAddr)) begin
            regs_d[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
          end
        end
      end
    end
  end

  // Register storage; contents are only meaningful once a sweep has run,
  // so the array itself carries no reset.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      regs_q[r] <= regs_d[r];
    end
  end

  // Combinational read ports: zero for address 0 or while sweeping,
  // optionally forwarding same-cycle write data with the highest port first.
  always_comb begin
    rdData_d = '0;
    for (int i = 0; i < NR; i++) begin
      if (!busy_q && (rd_addr[i*AW +: AW] != ZeroAddr)) begin
        rdData_d[i*DW +: DW] = regs_q[rd_addr[i*AW +: AW]];
`ifdef GPR_MP_BYPASS_EN
        for (int j = 0; j < NW; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
            rdData_d[i*DW +: DW] = wr_data[j*DW +: DW];
          end
        end
`else
`endif
      end
    end
  end

  assign rd_data = rdData_d;
  assign busy    = busy_q;

endmodule

// File: doc/gpr_mp.md
# gpr_mp

Parametrised multi-port general-purpose register file for the MIPS core, succeeding the single-write/dual-read GPR. It provides NR asynchronous read ports and NW synchronous write ports. Register 0 is hardwired to zero. A sequential clear engine zeroes the whole file after reset or on request, and optional write-to-read bypass is available. It sits between decode, which reads operands, and writeback, which writes results, and is sized for dual-issue configurations.

## Interface

Parameters:
- NREG, 32: number of registers; power of two, ≥ 2.
- DW, 32: data width in bits.
- NR, 2: number of read ports, ≥ 1.
- NW, 1: number of write ports, ≥ 1.
- AW, $clog2(NREG): address width; derived, not overridden.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset; synchronous and active-low.
- rd_addr, input, NR*AW: read addresses; port i occupies bits [i*AW +: AW].
- rd_data, output, NR*DW: read data; port i occupies bits [i*DW +: DW].
- wr_en, input, NW: per-port write enable.
- wr_addr, input, NW*AW: write addresses, packed like rd_addr.
- wr_data, input, NW*DW: write data, packed like rd_data.
- clr_req, input, 1: single-cycle request to zero the whole file.
- busy, output, 1: clear engine active; writes are ignored and reads return 0.

## Operation

- State machine states:
  - IDLE: normal operation.
  - CLEAR: the engine writes 0 to regfile[ptr] each cycle, then increments ptr.
- rst == 0 at an edge:
  - state ← CLEAR, ptr ← 0.
  - All other inputs are ignored.
- CLEAR behaviour:
  - When ptr == NREG-1, that register is cleared and state ← IDLE.
  - ptr is AW bits wide and wraps to 0 on exit.
- clr_req:
  - In IDLE: state ← CLEAR and ptr ← 0 at the next edge. Any writes presented in the same cycle still commit but are then overwritten by the sweep.
  - In CLEAR: ignored; the sweep is not restarted.
- Writes (IDLE only):
  - At each edge, for every port j with wr_en[j]=1 and wr_addr[j]≠0, regfile[wr_addr[j]] ← wr_data[j].
  - Writes to address 0 are discarded.
  - If several ports target the same address, the highest-index port wins.
- Reads:
  - Combinational.
  - rd_data[i] = 0 if rd_addr[i]==0 or busy==1; otherwise regfile[rd_addr[i]], subject to the bypass rule in Configuration.
- Reset values: busy = 1; rd_data = 0 on all ports.
- Register contents are undefined until the first sweep completes. They are never observable, because reads return 0 while busy.

## Timing

- Read latency: 0 cycles (combinational from rd_addr).
- Write latency: data written at edge k is readable from the register after edge k.
- Sweep length:
  - After rst rises, busy stays 1 for exactly NREG cycles.
  - The first write is accepted at edge NREG+1 after the first edge with rst == 1.
  - After clr_req in IDLE, busy is 1 from the next cycle for exactly NREG cycles.
- Reset mid-sweep: the sweep restarts from ptr 0 with the full NREG-cycle duration.
- busy is a registered output; there is no combinational path from clr_req to busy.

## Configuration

- Macro: GPR_MP_BYPASS_EN.
- Defined:
  - In IDLE, if wr_en[j]=1, wr_addr[j]==rd_addr[i] and the address is ≠ 0, rd_data[i] = wr_data[j] in the same cycle.
  - If several ports match, the highest matching j wins.
  - No bypass while busy, and none for address 0.
- Undefined:
  - rd_data[i] shows the pre-write contents in the write cycle and the new value from the next cycle.
  - No wr_* → rd_data combinational path exists.

## Test plan

- Reset sweep (NREG=32):
  - Hold rst=0 for 3 cycles, then release.
  - busy=1 for 32 cycles and reads are 0; on cycle 33 busy=0.
  - A write of 0xDEADBEEF to r5 is then readable on rd_data[0] the following cycle.
- Register 0 and collision (NW=2):
  - Port 0 writes 0x1111 to r0; ports 0 and 1 both write r7 (0xAAAA, 0xBBBB) in the same cycle.
  - Reading r0 returns 0; reading r7 returns 0xBBBB.
- Bypass:
  - Write 0x12345678 to r3 while reading r3 on port 1 in the same cycle.
  - With GPR_MP_BYPASS_EN, rd_data[1]=0x12345678 in that cycle.
  - Without it, rd_data[1] holds the old value (0 after the sweep) in that cycle and 0x12345678 in the next.
- clr_req with simultaneous write:
  - Fill r1..r31 with their own index, then assert clr_req together with a write of 0x55 to r9.
  - busy=1 for 32 cycles; afterwards every register reads 0.
  - Writes issued during busy have no effect.
- Reset mid-sweep:
  - Assert clr_req, wait 10 cycles, pulse rst=0 for 1 cycle.
  - busy stays 1 for a full 32 cycles after release.
- Multi-read (NR=4):
  - Read r1, r2, r31, r0 simultaneously after loading 1, 2, 31.
  - rd_data returns {0, 31, 2, 1} (port 3 down to port 0).
